// File: rtl/pbs_move_rng.sv
// Move source select, damage/accuracy lookup and LFSR-driven accuracy roll.
// A 16-bit Galois LFSR provides both the AI move and the accuracy roll.
module pbs_move_rng #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stop,
  input  logic       actr,
  input  logic [1:0] p_move,
  output logic [1:0] ai_move,
  output logic [3:0] moveaccurng,
  output logic [1:0] sel_move,
  output logic [3:0] dmg,
  output logic [3:0] accu,
  output logic       hit
);

  localparam logic [15:0] Taps = 16'hB400;

  logic [15:0] lfsr_q, lfsr_d;

  // Right-shifting Galois form; taps give a maximal 65535-state cycle.
  always_comb begin
    lfsr_d = lfsr_q;
    if (!stop) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? Taps : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign ai_move     = lfsr_q[1:0];
  assign moveaccurng = lfsr_q[5:2];
  assign sel_move    = actr ? ai_move : p_move;

  always_comb begin
    dmg  = 4'd4;
    accu = 4'd15;
    case (sel_move)
      2'd0: begin dmg = 4'd4;  accu = 4'd15; end
      2'd1: begin dmg = 4'd6;  accu = 4'd12; end
      2'd2: begin dmg = 4'd8;  accu = 4'd9;  end
      2'd3: begin dmg = 4'd12; accu = 4'd5;  end
      default: begin dmg = 4'd4; accu = 4'd15; end
    endcase
  end

  // Strict compare: accuracy 15 still misses on a roll of 15.
  assign hit = (moveaccurng < accu);

endmodule

// File: tb/tb_pbs_move_rng.sv
// Scoreboard bench for pbs_move_rng: directed cases plus a full-period
// free run against a reference LFSR model.
module tb_pbs_move_rng;

  logic       clk;
  logic       rst;
  logic       stop;
  logic       actr;
  logic [1:0] p_move;
  logic [1:0] ai_move;
  logic [3:0] moveaccurng;
  logic [1:0] sel_move;
  logic [3:0] dmg;
  logic [3:0] accu;
  logic       hit;

  pbs_move_rng dut (
    .clk         (clk),
    .rst         (rst),
    .stop        (stop),
    .actr        (actr),
    .p_move      (p_move),
    .ai_move     (ai_move),
    .moveaccurng (moveaccurng),
    .sel_move    (sel_move),
    .dmg         (dmg),
    .accu        (accu),
    .hit         (hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {lfsr, ai_move, moveaccurng, sel_move, dmg, accu, hit}
  logic [32:0] obs_v;
  assign obs_v = {dut.lfsr_q, ai_move, moveaccurng, sel_move, dmg, accu, hit};

  typedef struct {
    string       name;
    logic [32:0] v;
  } sb_t;

  sb_t sb_q[$];
  int  tests_run = 0;
  int  failed    = 0;

  function automatic logic [32:0] pack(input logic [15:0] l, input logic [1:0] ai,
                                       input logic [3:0] r, input logic [1:0] s,
                                       input logic [3:0] d, input logic [3:0] a,
                                       input logic h);
    return {l, ai, r, s, d, a, h};
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic [15:0] n;
    n = {1'b0, l[15:1]};
    if (l[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  function automatic logic [32:0] exp_vec(input logic [15:0] l, input logic a_sel,
                                          input logic [1:0] pm);
    logic [1:0] ai;
    logic [3:0] r;
    logic [1:0] s;
    logic [3:0] d;
    logic [3:0] a;
    ai = l[1:0];
    r  = l[5:2];
    s  = a_sel ? ai : pm;
    case (s)
      2'd0:    begin d = 4'd4;  a = 4'd15; end
      2'd1:    begin d = 4'd6;  a = 4'd12; end
      2'd2:    begin d = 4'd8;  a = 4'd9;  end
      default: begin d = 4'd12; a = 4'd5;  end
    endcase
    return pack(l, ai, r, s, d, a, (r < a));
  endfunction

  task automatic push_exp(input string n, input logic [32:0] v);
    sb_t e;
    e.name = n;
    e.v    = v;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b0;
    stop = 1'b1;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    sb_t e;
    do_reset();
    actr   = 1'b0;
    p_move = 2'd0;
    push_exp("reset_state", pack(16'hACE1, 2'd1, 4'd8, 2'd0, 4'd4, 4'd15, 1'b1));
    #1;
    e = sb_q.pop_front();
    tests_run++;
    if (obs_v !== e.v) begin
      failed++;
      $display("FAIL %s: got %h, required %h", e.name, obs_v, e.v);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      push_exp("stop_hold", pack(16'hACE1, 2'd1, 4'd8, 2'd0, 4'd4, 4'd15, 1'b1));
      e = sb_q.pop_front();
      tests_run++;
      if (obs_v !== e.v) begin
        failed++;
        $display("FAIL %s[%0d]: got %h, required %h", e.name, i, obs_v, e.v);
      end
    end
  endtask

  task automatic test_player_moves();
    sb_t e;
    actr = 1'b0;
    p_move = 2'd3;
    push_exp("player_m3", pack(16'hACE1, 2'd1, 4'd8, 2'd3, 4'd12, 4'd5, 1'b0));
    #1;
    e = sb_q.pop_front();
    tests_run++;
    if (obs_v !== e.v) begin
      failed++;
      $display("FAIL %s: got %h, required %h", e.name, obs_v, e.v);
    end
    p_move = 2'd2;
    push_exp("player_m2", pack(16'hACE1, 2'd1, 4'd8, 2'd2, 4'd8, 4'd9, 1'b1));
    #1;
    e = sb_q.pop_front();
    tests_run++;
    if (obs_v !== e.v) begin
      failed++;
      $display("FAIL %s: got %h, required %h", e.name, obs_v, e.v);
    end
    p_move = 2'd1;
    push_exp("player_m1", pack(16'hACE1, 2'd1, 4'd8, 2'd1, 4'd6, 4'd12, 1'b1));
    #1;
    e = sb_q.pop_front();
    tests_run++;
    if (obs_v !== e.v) begin
      failed++;
      $display("FAIL %s: got %h, required %h", e.name, obs_v, e.v);
    end
  endtask

  task automatic test_ai_select();
    sb_t e;
    actr = 1'b1;
    for (int pm = 0; pm < 4; pm++) begin
      p_move = pm[1:0];
      push_exp("ai_select", pack(16'hACE1, 2'd1, 4'd8, 2'd1, 4'd6, 4'd12, 1'b1));
      #1;
      e = sb_q.pop_front();
      tests_run++;
      if (obs_v !== e.v) begin
        failed++;
        $display("FAIL %s[p_move=%0d]: got %h, required %h", e.name, pm, obs_v, e.v);
      end
    end
  endtask

  task automatic test_single_step();
    sb_t e;
    do_reset();
    stop = 1'b0;
    tick();
    stop   = 1'b1;
    actr   = 1'b1;
    p_move = 2'd3;
    push_exp("step_ai", pack(16'hE270, 2'd0, 4'd12, 2'd0, 4'd4, 4'd15, 1'b1));
    #1;
    e = sb_q.pop_front();
    tests_run++;
    if (obs_v !== e.v) begin
      failed++;
      $display("FAIL %s: got %h, required %h", e.name, obs_v, e.v);
    end
    actr = 1'b0;
    push_exp("step_player_m3", pack(16'hE270, 2'd0, 4'd12, 2'd3, 4'd12, 4'd5, 1'b0));
    #1;
    e = sb_q.pop_front();
    tests_run++;
    if (obs_v !== e.v) begin
      failed++;
      $display("FAIL %s: got %h, required %h", e.name, obs_v, e.v);
    end
  endtask

  task automatic test_reset_priority();
    sb_t e;
    actr   = 1'b0;
    p_move = 2'd0;
    stop   = 1'b0;
    repeat (5) tick();
    rst  = 1'b0;
    stop = 1'b1;
    tick();
    rst = 1'b1;
    push_exp("rst_over_stop", pack(16'hACE1, 2'd1, 4'd8, 2'd0, 4'd4, 4'd15, 1'b1));
    #1;
    e = sb_q.pop_front();
    tests_run++;
    if (obs_v !== e.v) begin
      failed++;
      $display("FAIL %s: got %h, required %h", e.name, obs_v, e.v);
    end
    stop = 1'b0;
    repeat (7) tick();
    rst = 1'b0;
    tick();
    rst  = 1'b1;
    stop = 1'b1;
    push_exp("mid_seq_reset", pack(16'hACE1, 2'd1, 4'd8, 2'd0, 4'd4, 4'd15, 1'b1));
    #1;
    e = sb_q.pop_front();
    tests_run++;
    if (obs_v !== e.v) begin
      failed++;
      $display("FAIL %s: got %h, required %h", e.name, obs_v, e.v);
    end
  endtask

  task automatic test_free_run();
    sb_t         e;
    logic [15:0] mdl;
    int          first_ret;
    int          zero_seen;
    int          cyc_fail;
    first_ret = 0;
    zero_seen = 0;
    cyc_fail  = 0;
    do_reset();
    mdl  = 16'hACE1;
    stop = 1'b0;
    for (int i = 1; i <= 65535; i++) begin
      tick();
      mdl    = lfsr_step(mdl);
      actr   = 1'($urandom_range(0, 1));
      p_move = 2'($urandom_range(0, 3));
      push_exp("free_run", exp_vec(mdl, actr, p_move));
      #1;
      if (dut.lfsr_q == 16'h0000) zero_seen++;
      if (dut.lfsr_q == 16'hACE1 && first_ret == 0) first_ret = i;
      e = sb_q.pop_front();
      tests_run++;
      if (obs_v !== e.v) begin
        failed++;
        cyc_fail++;
        if (cyc_fail <= 20)
          $display("FAIL %s[cycle %0d]: got %h, required %h", e.name, i, obs_v, e.v);
      end
    end
    stop = 1'b1;
    tests_run++;
    if (first_ret !== 65535) begin
      failed++;
      $display("FAIL period: seed first returned after %0d clocks, required 65535", first_ret);
    end
    tests_run++;
    if (zero_seen !== 0) begin
      failed++;
      $display("FAIL never_zero: zero state seen %0d times, required 0", zero_seen);
    end
    tests_run++;
    if (dut.lfsr_q !== 16'hACE1) begin
      failed++;
      $display("FAIL wrap_value: got %h, required %h", dut.lfsr_q, 16'hACE1);
    end
  endtask

  initial begin
    rst    = 1'b0;
    stop   = 1'b1;
    actr   = 1'b0;
    p_move = 2'd0;
    test_reset();
    test_player_moves();
    test_ai_select();
    test_single_step();
    test_reset_priority();
    test_free_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
